// File: rtl/msi_pkg.sv
// rtl/msi_pkg.sv - shared bus command, FSM state and MSI encodings for the two-core snooping bus
package msi_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        BUS_NONE = 2'b00,
        BUS_RD   = 2'b01,
        BUS_RDX  = 2'b10,
        BUS_UPGR = 2'b11
    } bus_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_MEMRD,
        ST_WB,
        ST_DONE
    } bus_state_e;

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b10
    } msi_state_e;

    // An illegal (zero) command is carried through the bus as an upgrade.
    function automatic bus_cmd_e legal_cmd(input logic [1:0] cmd);
        return (cmd == 2'b00) ? BUS_UPGR : bus_cmd_e'(cmd);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin picker whose pointer advances only on transaction completion
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_idx,
    output logic       any,
    output logic       win_idx
);

    logic last_q;
    logic last_d;

    always_comb begin
        last_d = update ? upd_idx : last_q;
    end

    always_comb begin
        any = |req;
        if (req == 2'b11) begin
            win_idx = ~last_q;
        end else begin
            win_idx = req[1] & ~req[0];
        end
    end

    // Seeding "last winner" with 1 gives cache 0 the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/msi_bus_arbiter.sv
// rtl/msi_bus_arbiter.sv - snooping bus controller: arbitration, snoop forwarding, flush/memory data sourcing
module msi_bus_arbiter
    import msi_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MEM_LAT  = 1,
    parameter int SNOOP_TO = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [1:0]        cmd0,
    input  logic [1:0]        cmd1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [1:0]        gnt,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              snoop_valid,
    output logic [1:0]        snoop_cmd,
    output logic [ADDR_W-1:0] snoop_addr,
    input  logic              snoop_ack,
    input  logic              snoop_hit,
    input  logic [DATA_W-1:0] snoop_data,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    bus_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    bus_cmd_e          cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       to_cnt_q, to_cnt_d;
    logic [15:0]       lat_cnt_q, lat_cnt_d;

    logic arb_any;
    logic arb_win;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({req1, req0}),
        .update  (state_q == ST_DONE),
        .upd_idx (owner_q),
        .any     (arb_any),
        .win_idx (arb_win)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        to_cnt_d    = to_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        gnt         = 2'b00;
        done0       = 1'b0;
        done1       = 1'b0;
        rdata       = '0;
        snoop_valid = 1'b0;
        snoop_cmd   = cmd_q;
        snoop_addr  = addr_q;
        mem_rd      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        if (state_q != ST_IDLE) begin
            gnt = owner_q ? 2'b10 : 2'b01;
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    owner_d   = arb_win;
                    cmd_d     = legal_cmd(arb_win ? cmd1 : cmd0);
                    addr_d    = arb_win ? addr1 : addr0;
                    data_d    = '0;
                    to_cnt_d  = '0;
                    lat_cnt_d = '0;
                    state_d   = ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                snoop_valid = 1'b1;
                to_cnt_d    = to_cnt_q + 16'd1;
                if (snoop_ack) begin
                    if (cmd_q == BUS_UPGR) begin
                        state_d = ST_DONE;
                    end else if (snoop_hit) begin
                        data_d  = snoop_data;
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_MEMRD;
                    end
                end else if (to_cnt_q == 16'(SNOOP_TO - 1)) begin
                    state_d = (cmd_q == BUS_UPGR) ? ST_DONE : ST_MEMRD;
                end
            end
            ST_MEMRD: begin
                lat_cnt_d = lat_cnt_q + 16'd1;
                if (lat_cnt_q == 16'd0) begin
                    mem_rd   = 1'b1;
                    mem_addr = addr_q;
                end
                if (lat_cnt_q == 16'(MEM_LAT)) begin
                    data_d  = mem_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_WB: begin
                // A reset landing on this cycle must not commit the write.
                mem_we    = ~reset;
                mem_addr  = addr_q;
                mem_wdata = data_q;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                done0   = ~reset & ~owner_q;
                done1   = ~reset & owner_q;
                rdata   = reset ? '0 : data_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            cmd_q     <= BUS_NONE;
            addr_q    <= '0;
            data_q    <= '0;
            to_cnt_q  <= '0;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            to_cnt_q  <= to_cnt_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// tb/tb_msi_bus_arbiter.sv - scoreboard bench for msi_bus_arbiter with snoop responder and memory model
module tb_msi_bus_arbiter;

    localparam int MEM_LAT  = 1;
    localparam int SNOOP_TO = 8;

    typedef struct {
        int          ack_dly;
        bit          hit;
        logic [15:0] sdata;
    } plan_t;

    typedef struct {
        bit          owner;
        logic [1:0]  scmd;
        logic [8:0]  addr;
        logic [15:0] rdata;
        bit          rd;
        bit          wb;
        logic [15:0] wdata;
        int          lat;
        int          slen;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [1:0]  cmd0 = 2'b00, cmd1 = 2'b00;
    logic [8:0]  addr0 = '0, addr1 = '0;
    logic [1:0]  gnt;
    logic        done0, done1;
    logic [15:0] rdata;
    logic        snoop_valid;
    logic [1:0]  snoop_cmd;
    logic [8:0]  snoop_addr;
    logic        snoop_ack = 1'b0, snoop_hit = 1'b0;
    logic [15:0] snoop_data = '0;
    logic        mem_rd, mem_we;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [15:0] bmem[512];
    logic [15:0] ref_mem[512];
    bit          ref_prio = 1'b0;

    msi_bus_arbiter #(.ADDR_W(9), .DATA_W(16), .MEM_LAT(MEM_LAT), .SNOOP_TO(SNOOP_TO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1), .addr0(addr0), .addr1(addr1),
        .gnt(gnt), .done0(done0), .done1(done1), .rdata(rdata),
        .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
        .snoop_ack(snoop_ack), .snoop_hit(snoop_hit), .snoop_data(snoop_data),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference outcome of one granted transaction, from the bus rules alone.
    function automatic exp_t model(bit who, logic [1:0] c, logic [8:0] a, plan_t p);
        exp_t e;
        bit   acked;
        int   d;
        e.owner = who;
        e.addr  = a;
        e.scmd  = (c == 2'b00) ? 2'b11 : c;
        e.rd    = 1'b0;
        e.wb    = 1'b0;
        e.wdata = '0;
        e.rdata = '0;
        acked   = (p.ack_dly < SNOOP_TO);
        d       = acked ? p.ack_dly : SNOOP_TO - 1;
        e.slen  = d + 1;
        if (e.scmd == 2'b11) begin
            e.lat = d + 1;
        end else if (acked && p.hit) begin
            e.wb       = 1'b1;
            e.wdata    = p.sdata;
            e.rdata    = p.sdata;
            ref_mem[a] = p.sdata;
            e.lat      = d + 2;
        end else begin
            e.rd    = 1'b1;
            e.rdata = ref_mem[a];
            e.lat   = d + 2 + MEM_LAT;
        end
        return e;
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        exp_q.delete();
        plan_q.delete();
        ref_prio = 1'b0;
    endtask

    task automatic run_round(input bit r0, input bit r1, input logic [1:0] c0, input logic [1:0] c1,
                             input logic [8:0] a0, input logic [8:0] a1, input plan_t p0, input plan_t p1);
        bit first;
        bit who;
        first = (r0 && r1) ? ref_prio : r1;
        for (int k = 0; k < ((r0 && r1) ? 2 : 1); k++) begin
            who = (k == 0) ? first : ~first;
            plan_q.push_back(who ? p1 : p0);
            exp_q.push_back(model(who, who ? c1 : c0, who ? a1 : a0, who ? p1 : p0));
            ref_prio = ~who;
        end
        @(negedge clk);
        cmd0 = c0; cmd1 = c1; addr0 = a0; addr1 = a1;
        req0 = r0; req1 = r1;
        for (int n = 0; n < 400 && (req0 || req1); n++) begin
            @(negedge clk);
            if (done0) req0 = 1'b0;
            if (done1) req1 = 1'b0;
        end
        if (req0 || req1) begin
            checks++;
            errors++;
            $display("FAIL round_timeout actual=req_pending expected=done_within_400");
            pulse_reset();
        end
    endtask

    function automatic plan_t rand_plan();
        plan_t p;
        p.ack_dly = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, SNOOP_TO - 1));
        p.hit     = 1'($urandom_range(0, 1));
        p.sdata   = 16'($urandom);
        return p;
    endfunction

    // Snoop responder: answers each snoop per its plan, drives noise otherwise.
    initial begin
        plan_t cur;
        bit    active = 1'b0;
        int    scnt = 0;
        forever begin
            @(negedge clk);
            if (reset || !snoop_valid) begin
                active     = 1'b0;
                snoop_ack  = 1'($urandom_range(0, 1));
                snoop_hit  = 1'($urandom_range(0, 1));
                snoop_data = 16'($urandom);
            end else begin
                if (!active) begin
                    active = 1'b1;
                    scnt   = 0;
                    if (plan_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_snoop actual=snoop_valid expected=no_snoop");
                        cur = '{ack_dly: 255, hit: 1'b0, sdata: 16'h0};
                    end else begin
                        cur = plan_q.pop_front();
                    end
                end else begin
                    scnt++;
                end
                if (scnt == cur.ack_dly) begin
                    snoop_ack  = 1'b1;
                    snoop_hit  = cur.hit;
                    snoop_data = cur.sdata;
                end else begin
                    snoop_ack  = 1'b0;
                    snoop_hit  = 1'($urandom_range(0, 1));
                    snoop_data = 16'($urandom);
                end
            end
        end
    end

    // Memory: read data valid MEM_LAT cycles after mem_rd, noise otherwise.
    initial begin
        bit         rd_s, we_s, pend;
        logic [8:0] a_s, paddr;
        logic [15:0] wd_s;
        int         pcnt;
        pend = 1'b0;
        pcnt = 0;
        paddr = '0;
        forever begin
            @(negedge clk);
            rd_s = mem_rd; we_s = mem_we; a_s = mem_addr; wd_s = mem_wdata;
            @(posedge clk);
            #1;
            if (we_s) bmem[a_s] = wd_s;
            if (rd_s) begin
                pend  = 1'b1;
                pcnt  = MEM_LAT - 1;
                paddr = a_s;
            end else if (pend) begin
                pcnt--;
            end
            if (pend && pcnt == 0) begin
                mem_rdata = bmem[paddr];
                pend      = 1'b0;
            end else begin
                mem_rdata = 16'($urandom);
            end
        end
    end

    // Monitor: compares DUT activity against the head of the expectation queue.
    initial begin
        exp_t hd;
        int   cyc = 0, gcyc = 0, slen = 0;
        bit   gnt_prev = 1'b0, sv_prev = 1'b0, rd_seen = 1'b0, we_seen = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (gnt != 2'b00 && !gnt_prev) begin
                    rd_seen = 1'b0;
                    we_seen = 1'b0;
                    gcyc    = cyc;
                    chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_gnt", 32'(gnt), 32'd0);
                    end else begin
                        hd = exp_q[0];
                        chk("gnt_owner", 32'(gnt), hd.owner ? 32'd2 : 32'd1);
                    end
                end
                if (snoop_valid && exp_q.size() != 0) begin
                    hd = exp_q[0];
                    if (!sv_prev) begin
                        slen = 0;
                        chk("snoop_cmd", 32'(snoop_cmd), 32'(hd.scmd));
                        chk("snoop_addr", 32'(snoop_addr), 32'(hd.addr));
                    end
                    slen++;
                end
                if (!snoop_valid && sv_prev && exp_q.size() != 0) begin
                    chk("snoop_len", 32'(slen), 32'(exp_q[0].slen));
                end
                if (mem_rd) begin
                    rd_seen = 1'b1;
                    if (exp_q.size() == 0) chk("mem_rd_unexpected", 32'd1, 32'd0);
                    else begin
                        chk("mem_rd_allowed", 32'd1, 32'(exp_q[0].rd));
                        chk("mem_rd_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                    end
                end
                if (mem_we) begin
                    we_seen = 1'b1;
                    if (exp_q.size() == 0) chk("mem_we_unexpected", 32'd1, 32'd0);
                    else begin
                        chk("mem_we_allowed", 32'd1, 32'(exp_q[0].wb));
                        chk("mem_we_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                        chk("mem_we_data", 32'(mem_wdata), 32'(exp_q[0].wdata));
                    end
                end
                if (done0 || done1) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", {30'd0, done1, done0}, 32'd0);
                    end else begin
                        hd = exp_q.pop_front();
                        chk("done_onehot", {30'd0, done1, done0}, hd.owner ? 32'd2 : 32'd1);
                        chk("rdata", 32'(rdata), 32'(hd.rdata));
                        chk("latency", 32'(cyc - gcyc), 32'(hd.lat));
                        chk("mem_rd_issued", 32'(rd_seen), 32'(hd.rd));
                        chk("mem_we_issued", 32'(we_seen), 32'(hd.wb));
                    end
                end
            end
            gnt_prev = (gnt != 2'b00);
            sv_prev  = snoop_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        plan_t      p0, p1, pz;
        logic [15:0] v;
        bit          seen;
        for (int i = 0; i < 512; i++) begin
            v = 16'($urandom);
            bmem[i]    = v;
            ref_mem[i] = v;
        end
        bmem[9'h010]    = 16'hBEEF;
        ref_mem[9'h010] = 16'hBEEF;
        pz = '{ack_dly: 0, hit: 1'b0, sdata: 16'h0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", {30'd0, done1, done0}, 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_snoop_valid", 32'(snoop_valid), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

        run_round(1, 0, 2'b01, 2'b00, 9'h010, 9'h000, pz, pz);
        run_round(0, 1, 2'b00, 2'b10, 9'h000, 9'h1A0, pz, '{ack_dly: 0, hit: 1'b1, sdata: 16'h1234});
        run_round(1, 1, 2'b01, 2'b10, 9'h020, 9'h021, rand_plan(), rand_plan());
        run_round(1, 1, 2'b10, 2'b01, 9'h022, 9'h023, rand_plan(), rand_plan());
        run_round(1, 0, 2'b11, 2'b00, 9'h005, 9'h000, pz, pz);
        run_round(1, 0, 2'b01, 2'b00, 9'h030, 9'h000, '{ack_dly: 255, hit: 1'b0, sdata: 16'h0}, pz);
        run_round(0, 1, 2'b11, 2'b11, 9'h000, 9'h031, pz, '{ack_dly: 255, hit: 1'b1, sdata: 16'h5A5A});

        for (int r = 0; r < 60; r++) begin
            p0 = rand_plan();
            p1 = rand_plan();
            case ($urandom_range(0, 2))
                0: run_round(1, 0, 2'($urandom), 2'($urandom), 9'($urandom_range(0, 15)), 9'($urandom), p0, p1);
                1: run_round(0, 1, 2'($urandom), 2'($urandom), 9'($urandom), 9'($urandom_range(0, 15)), p0, p1);
                default: run_round(1, 1, 2'($urandom), 2'($urandom), 9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)), p0, p1);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Leave the pointer favouring cache 1, then abort a read with reset.
        run_round(1, 0, 2'b01, 2'b00, 9'h040, 9'h000, pz, pz);
        plan_q.push_back(pz);
        exp_q.push_back(model(1'b0, 2'b01, 9'h041, pz));
        @(negedge clk);
        cmd0 = 2'b01; addr0 = 9'h041; req0 = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = mem_rd;
        end
        chk("abort_reached_memrd", 32'(seen), 32'd1);
        pulse_reset();
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_done", {30'd0, done1, done0}, 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        chk("abort_snoop_valid", 32'(snoop_valid), 32'd0);
        chk("abort_mem", {29'd0, mem_rd, mem_we, 1'b0}, 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        run_round(1, 1, 2'b01, 2'b01, 9'h042, 9'h043, pz, pz);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
